// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, the FSM state
// encoding and the layout of the status byte returned to the host.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_STATUS  = 8'h05;
  localparam logic [7:0] STALL_BYTE = 8'hFF;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_OVERRUN_BIT = 1;

  // Clocks after a byte boundary within which read data must be presented
  // before the slave is assumed to have started shifting the next byte.
  localparam logic [3:0] LOAD_WINDOW = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WRITE,
    READ,
    STATUS,
    IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic overrun, input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY_BIT]    = busy;
    s[STAT_OVERRUN_BIT] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_req.sv
// Register-bus request holder: captures one write or read request and keeps
// it asserted until the target acknowledges it.
module spi_bus_req (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_we,
  input  logic       issue_re,
  input  logic [7:0] issue_addr,
  input  logic [7:0] issue_wdata,
  input  logic       bus_ack,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  output logic       busy
);

  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;

  // New requests are only accepted when nothing is outstanding, so we/re
  // can never be high together and a request is never replaced mid-handshake.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    re_d    = re_q;
    if (we_q || re_q) begin
      if (bus_ack) begin
        we_d = 1'b0;
        re_d = 1'b0;
      end
    end else if (issue_we) begin
      we_d    = 1'b1;
      addr_d  = issue_addr;
      wdata_d = issue_wdata;
    end else if (issue_re) begin
      re_d   = 1'b1;
      addr_d = issue_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_re    = re_q;
  assign busy      = we_q | re_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI slave byte engine: decodes write, read and
// status frames into register-bus requests and feeds the slave's transmit byte.
module spi_cmd_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       SSEL,
  input  logic       byte_received,
  input  logic [7:0] byte_data_received,
  output logic [7:0] byte_send,
  output logic       send_latch,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       frame_active,
  output logic       overrun
);

  import spi_cmd_pkg::*;

  logic       ssel_meta_q, ssel_meta_d;
  logic       ssel_sync_q, ssel_sync_d;
  state_t     state_q, state_d;
  logic       is_read_q, is_read_d;
  logic [7:0] addr_q, addr_d;
  logic       pend_re_q, pend_re_d;
  logic       send_latch_q, send_latch_d;
  logic [7:0] byte_send_q, byte_send_d;
  logic       overrun_q, overrun_d;
  logic [3:0] win_cnt_q, win_cnt_d;

  logic       frame_act;
  logic       busy;
  logic       issue_we, issue_re;
  logic [7:0] issue_addr;
  logic       rd_hit;
  logic       win_open;
  logic       overrun_set, overrun_clr;

  assign frame_act = ~ssel_sync_q;
  assign win_open  = (win_cnt_q != LOAD_WINDOW);

  // Read data is only used when it belongs to the current slot's address and
  // the slot has not already been filled (by data or by a stall byte).
  assign rd_hit = bus_ack && bus_re && (bus_addr == addr_q) && !send_latch_q
                  && !byte_received;

  always_comb begin
    ssel_meta_d  = SSEL;
    ssel_sync_d  = ssel_meta_q;
    state_d      = state_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    pend_re_d    = pend_re_q;
    send_latch_d = send_latch_q;
    byte_send_d  = byte_send_q;
    win_cnt_d    = win_open ? win_cnt_q + 4'd1 : win_cnt_q;
    issue_we     = 1'b0;
    issue_re     = 1'b0;
    issue_addr   = addr_q;
    overrun_set  = 1'b0;
    overrun_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_act) state_d = CMD;
      end
      CMD: begin
        if (byte_received) begin
          if (byte_data_received == OP_WRITE || byte_data_received == OP_READ) begin
            state_d   = ADDR;
            is_read_d = (byte_data_received == OP_READ);
          end else if (byte_data_received == OP_STATUS) begin
            state_d = STATUS;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      ADDR: begin
        if (byte_received) begin
          addr_d = byte_data_received;
          if (is_read_q) begin
            state_d      = READ;
            win_cnt_d    = 4'd0;
            send_latch_d = 1'b0;
            if (!busy) begin
              issue_re   = 1'b1;
              issue_addr = byte_data_received;
              pend_re_d  = 1'b0;
            end else begin
              pend_re_d = 1'b1;
            end
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (byte_received) begin
          if (!busy) begin
            issue_we   = 1'b1;
            issue_addr = addr_q;
            addr_d     = addr_q + 8'd1;
          end else begin
            overrun_set = 1'b1;
          end
        end
      end
      READ: begin
        if (byte_received) begin
          addr_d       = addr_q + 8'd1;
          send_latch_d = 1'b0;
          win_cnt_d    = 4'd0;
          if (!busy) begin
            issue_re   = 1'b1;
            issue_addr = addr_q + 8'd1;
            pend_re_d  = 1'b0;
          end else begin
            pend_re_d = 1'b1;
          end
        end else begin
          if (pend_re_q && !busy) begin
            issue_re  = 1'b1;
            pend_re_d = 1'b0;
          end
          // A stalled slot still lets its late read complete; the data is
          // simply not presented because the slot already carries STALL_BYTE.
          if (rd_hit) begin
            byte_send_d  = bus_rdata;
            send_latch_d = 1'b1;
          end else if (!send_latch_q && !win_open) begin
            byte_send_d  = STALL_BYTE;
            send_latch_d = 1'b1;
          end
        end
      end
      STATUS: begin
        if (byte_received) overrun_clr = 1'b1;
      end
      IGNORE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame abort: the FSM unwinds, but any request already on the bus is
    // left to the request holder so the handshake completes normally.
    if (state_q != IDLE && !frame_act) begin
      state_d      = IDLE;
      issue_we     = 1'b0;
      issue_re     = 1'b0;
      pend_re_d    = 1'b0;
      send_latch_d = 1'b0;
      byte_send_d  = 8'h00;
    end

    overrun_d = overrun_q;
    if (overrun_set)      overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ssel_meta_q  <= 1'b1;
      ssel_sync_q  <= 1'b1;
      state_q      <= IDLE;
      is_read_q    <= 1'b0;
      addr_q       <= 8'h00;
      pend_re_q    <= 1'b0;
      send_latch_q <= 1'b0;
      byte_send_q  <= 8'h00;
      overrun_q    <= 1'b0;
      win_cnt_q    <= 4'd0;
    end else begin
      ssel_meta_q  <= ssel_meta_d;
      ssel_sync_q  <= ssel_sync_d;
      state_q      <= state_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      pend_re_q    <= pend_re_d;
      send_latch_q <= send_latch_d;
      byte_send_q  <= byte_send_d;
      overrun_q    <= overrun_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  spi_bus_req u_bus_req (
    .clk         (clk),
    .rst         (rst),
    .issue_we    (issue_we),
    .issue_re    (issue_re),
    .issue_addr  (issue_addr),
    .issue_wdata (byte_data_received),
    .bus_ack     (bus_ack),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .busy        (busy)
  );

  assign byte_send    = (state_q == STATUS) ? status_byte(overrun_q, busy) : byte_send_q;
  assign send_latch   = (state_q == STATUS) | send_latch_q;
  assign frame_active = frame_act;
  assign overrun      = overrun_q;

endmodule
